booth_r4_mult_seq: RTL and testbench

//  Parametrised sequential radix-4 Booth multiplier, the generalised successor to the fixed 8x8 Booth datapath/controller pair.

---
 rtl/booth_r4_mult_seq.sv | 172 +++++++++++++++++
 tb/tb_booth_r4_mult_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_r4_mult_seq.sv
// rtl/booth_r4_mult_seq.sv - Sequential radix-4 Booth multiplier with start/busy/done handshake
//
// Purpose: multiplies two WIDTH-bit operands (signed or unsigned, chosen per
// operation) by retiring one radix-4 Booth digit per clock. One multiply in
// flight at a time.
//
// Ports:
//   clk          in   1        clock, rising edge
//   rst          in   1        asynchronous active-low reset
//   start        in   1        request, sampled only in IDLE or DONE
//   signed_mode  in   1        1 = two's-complement operands, 0 = unsigned
//   mcand        in   WIDTH    multiplicand, sampled with start
//   mplier       in   WIDTH    multiplier, sampled with start
//   busy         out  1        high while the multiply is running
//   done         out  1        one-cycle pulse, product valid
//   product      out  2*WIDTH  result, held until the next done

module booth_r4_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  if (((WIDTH % 2) != 0) || (WIDTH < 4)) begin : g_width_check
    $error("booth_r4_mult_seq: WIDTH must be even and >= 4");
  end

  localparam int ITER = WIDTH / 2 + 1;
  localparam int AW   = WIDTH + 3;          // accumulator width
  localparam int MW   = WIDTH + 2;          // extended multiplier width
  localparam int CW   = $clog2(ITER + 1);   // step counter width

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic [AW-1:0]        acc_q;
  logic [MW-1:0]        mp_q;
  logic                 guard_q;
  logic [WIDTH:0]       m_q;
  logic [CW-1:0]        cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic [2*WIDTH-1:0]   prod_q;

  logic [AW-1:0]        acc_d;
  logic [MW-1:0]        mp_d;
  logic                 guard_d;

  // Load-time extension bits: sign bits in signed mode, zeros otherwise.
  logic                 s_mc;
  logic                 s_mp;
  assign s_mc = signed_mode & mcand[WIDTH-1];
  assign s_mp = signed_mode & mplier[WIDTH-1];

  // One Booth step: recode the triplet, add/subtract M or 2M, then
  // arithmetic-shift the whole {acc, mplier, guard} chain right by two.
  logic [2:0]           trip;
  logic [AW-1:0]        m_ext;
  logic [AW-1:0]        m2_ext;
  logic [AW-1:0]        addend;
  logic                 sub;
  logic [AW-1:0]        sum;
  logic [AW+MW:0]       shifted;

  assign trip   = {mp_q[1:0], guard_q};
  assign m_ext  = {{2{m_q[WIDTH]}}, m_q};
  assign m2_ext = {m_q[WIDTH], m_q, 1'b0};

  always_comb begin
    addend = '0;
    sub    = 1'b0;
    case (trip)
      3'b001, 3'b010: addend = m_ext;
      3'b011:         addend = m2_ext;
      3'b100: begin
        addend = m2_ext;
        sub    = 1'b1;
      end
      3'b101, 3'b110: begin
        addend = m_ext;
        sub    = 1'b1;
      end
      default:        addend = '0;
    endcase
    sum     = sub ? (acc_q - addend) : (acc_q + addend);
    // The bit leaving the multiplier at position 1 becomes the new guard.
    shifted = {{2{sum[AW-1]}}, sum, mp_q[MW-1:1]};
  end

  assign acc_d   = shifted[AW+MW -: AW];
  assign mp_d    = shifted[MW:1];
  assign guard_d = shifted[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      mp_q    <= '0;
      guard_q <= 1'b0;
      m_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      prod_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            acc_q   <= '0;
            mp_q    <= {{2{s_mp}}, mplier};
            guard_q <= 1'b0;
            m_q     <= {s_mc, mcand};
            cnt_q   <= CW'(ITER);
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (cnt_q != '0) begin
            acc_q   <= acc_d;
            mp_q    <= mp_d;
            guard_q <= guard_d;
            cnt_q   <= cnt_q - CW'(1);
          end else begin
            // All digits retired: the low 2*WIDTH bits of {acc, mplier}
            // hold the exact product for both modes.
            prod_q  <= {acc_q[WIDTH-3:0], mp_q};
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            acc_q   <= '0;
            mp_q    <= {{2{s_mp}}, mplier};
            guard_q <= 1'b0;
            m_q     <= {s_mc, mcand};
            cnt_q   <= CW'(ITER);
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = prod_q;

endmodule

// File: tb/tb_booth_r4_mult_seq.sv
// tb/tb_booth_r4_mult_seq.sv - Self-checking bench for booth_r4_mult_seq (WIDTH 8, 4 and 16)

module tb_booth_r4_mult_seq;

  logic clk;
  logic rst;

  logic        st8, sm8;
  logic [7:0]  mc8, mp8;
  logic        bz8, dn8;
  logic [15:0] pr8;

  logic        st4, sm4;
  logic [3:0]  mc4, mp4;
  logic        bz4, dn4;
  logic [7:0]  pr4;

  logic        st16, sm16;
  logic [15:0] mc16, mp16;
  logic        bz16, dn16;
  logic [31:0] pr16;

  int checks;
  int errors;

  booth_r4_mult_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(st8), .signed_mode(sm8),
    .mcand(mc8), .mplier(mp8), .busy(bz8), .done(dn8), .product(pr8)
  );

  booth_r4_mult_seq #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(st4), .signed_mode(sm4),
    .mcand(mc4), .mplier(mp4), .busy(bz4), .done(dn4), .product(pr4)
  );

  booth_r4_mult_seq #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(st16), .signed_mode(sm16),
    .mcand(mc16), .mplier(mp16), .busy(bz16), .done(dn16), .product(pr16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer multiply of the operands interpreted per mode,
  // truncated to 2*w bits.
  function automatic longint ref_mul(input int w, input logic sm, input longint a, input longint b);
    longint x, y, mask_w;
    mask_w = (longint'(1) << w) - 1;
    x = a & mask_w;
    y = b & mask_w;
    if (sm && x[w-1]) x = x - (longint'(1) << w);
    if (sm && y[w-1]) y = y - (longint'(1) << w);
    return (x * y) & ((longint'(1) << (2 * w)) - 1);
  endfunction

  task automatic drive_ops(input int w, input logic s, input logic sm, input longint a, input longint b);
    case (w)
      4:  begin st4 = s;  sm4 = sm;  mc4 = a[3:0];   mp4 = b[3:0];   end
      16: begin st16 = s; sm16 = sm; mc16 = a[15:0]; mp16 = b[15:0]; end
      default: begin st8 = s; sm8 = sm; mc8 = a[7:0]; mp8 = b[7:0]; end
    endcase
  endtask

  task automatic drive_start(input int w, input logic s);
    case (w)
      4:       st4 = s;
      16:      st16 = s;
      default: st8 = s;
    endcase
  endtask

  function automatic logic get_done(input int w);
    case (w)
      4:       return dn4;
      16:      return dn16;
      default: return dn8;
    endcase
  endfunction

  function automatic logic get_busy(input int w);
    case (w)
      4:       return bz4;
      16:      return bz16;
      default: return bz8;
    endcase
  endfunction

  function automatic longint get_prod(input int w);
    case (w)
      4:       return longint'(pr4);
      16:      return longint'(pr16);
      default: return longint'(pr8);
    endcase
  endfunction

  // Called at the negedge of the cycle that begins with the start-sampling
  // edge. Counts cycles until done, checking busy and product hold meanwhile.
  task automatic wait_done(input int w, input int repulse_at, input logic hold_start,
                           input string tag, output int lat);
    longint prev_p;
    prev_p = get_prod(w);
    lat = -1;
    for (int c = 0; c < 64; c++) begin
      if (get_done(w)) begin
        lat = c;
        break;
      end
      check({tag, " busy"}, longint'(get_busy(w)), longint'(1));
      check({tag, " hold"}, get_prod(w), prev_p);
      if (c == repulse_at)
        drive_ops(w, 1'b1, 1'($urandom_range(0, 1)), longint'($urandom), longint'($urandom));
      else
        drive_start(w, hold_start);
      @(negedge clk);
    end
    check({tag, " latency"}, longint'(lat), longint'(w / 2 + 2));
    check({tag, " busy_at_done"}, longint'(get_busy(w)), longint'(0));
  endtask

  task automatic run_op(input int w, input logic sm, input longint a, input longint b,
                        input longint exp_p, input int repulse_at, input string tag);
    int lat;
    @(negedge clk);
    drive_ops(w, 1'b1, sm, a, b);
    @(negedge clk);
    drive_start(w, 1'b0);
    wait_done(w, repulse_at, 1'b0, tag, lat);
    check({tag, " product"}, get_prod(w), exp_p);
    @(negedge clk);
    check({tag, " done_pulse"}, longint'(get_done(w)), longint'(0));
    check({tag, " product_held"}, get_prod(w), exp_p);
  endtask

  initial begin
    int     lat;
    longint ea, eb, a, b;
    logic   sm;

    checks = 0;
    errors = 0;
    rst = 1'b0;
    drive_ops(8, 1'b0, 1'b0, 0, 0);
    drive_ops(4, 1'b0, 1'b0, 0, 0);
    drive_ops(16, 1'b0, 1'b0, 0, 0);
    repeat (3) @(negedge clk);
    check("reset busy8", longint'(bz8), longint'(0));
    check("reset done8", longint'(dn8), longint'(0));
    check("reset prod8", longint'(pr8), longint'(0));
    check("reset prod4", longint'(pr4), longint'(0));
    check("reset prod16", longint'(pr16), longint'(0));
    rst = 1'b1;
    @(negedge clk);
    check("idle busy8", longint'(bz8), longint'(0));

    // Directed WIDTH=8 cases with spec-given results.
    run_op(8, 1'b1, 64'h80, 64'h80, 64'h4000, -1, "t1 -128*-128");
    run_op(8, 1'b0, 64'hFF, 64'hFF, 64'hFE01, -1, "t2 255*255 u");
    run_op(8, 1'b1, 64'hFF, 64'hFF, 64'h0001, -1, "t2 -1*-1 s");
    run_op(8, 1'b1, 64'hFF, 64'h01, 64'hFFFF, -1, "t3 -1*1");
    run_op(8, 1'b1, 64'h00, 64'hB3, 64'h0000, -1, "t3 0*-77");
    run_op(8, 1'b1, 64'h7F, 64'h80, 64'hC080, -1, "t3 127*-128");

    // Asynchronous abort two cycles into RUN; product is nonzero beforehand.
    @(negedge clk);
    drive_ops(8, 1'b1, 1'b1, 64'h5A, 64'h33);
    @(negedge clk);
    drive_start(8, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("t5 busy_async", longint'(bz8), longint'(0));
    check("t5 done_async", longint'(dn8), longint'(0));
    check("t5 prod_async", longint'(pr8), longint'(0));
    @(negedge clk);
    rst = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("t5 no_done", longint'(dn8), longint'(0));
      check("t5 idle", longint'(bz8), longint'(0));
    end
    run_op(8, 1'b1, 64'h5A, 64'h33, ref_mul(8, 1'b1, 64'h5A, 64'h33), -1, "t5 after_abort");

    // start re-pulsed with other operands during RUN is ignored.
    run_op(8, 1'b1, 64'h9C, 64'h47, ref_mul(8, 1'b1, 64'h9C, 64'h47), 2, "t4 repulse");
    run_op(8, 1'b0, 64'hD2, 64'h3B, ref_mul(8, 1'b0, 64'hD2, 64'h3B), 0, "t4 repulse0");

    // start held high across DONE: second multiply begins straight from DONE.
    ea = ref_mul(8, 1'b1, 64'h35, 64'hE9);
    eb = ref_mul(8, 1'b0, 64'hC3, 64'h7E);
    @(negedge clk);
    drive_ops(8, 1'b1, 1'b1, 64'h35, 64'hE9);
    @(negedge clk);
    drive_ops(8, 1'b1, 1'b0, 64'hC3, 64'h7E);
    wait_done(8, -1, 1'b1, "t4 b2b first", lat);
    check("t4 b2b first product", longint'(pr8), ea);
    @(negedge clk);
    drive_start(8, 1'b0);
    check("t4 b2b no_idle", longint'(bz8), longint'(1));
    wait_done(8, -1, 1'b0, "t4 b2b second", lat);
    check("t4 b2b second product", longint'(pr8), eb);
    @(negedge clk);
    check("t4 b2b done_pulse", longint'(dn8), longint'(0));

    // Random WIDTH=8 operations in both modes.
    for (int i = 0; i < 40; i++) begin
      a  = longint'($urandom);
      b  = longint'($urandom);
      sm = 1'($urandom_range(0, 1));
      run_op(8, sm, a, b, ref_mul(8, sm, a, b), -1, $sformatf("w8 rnd %0d", i));
    end

    // WIDTH=4 exhaustive, both modes.
    for (int m = 0; m < 2; m++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          run_op(4, 1'(m), longint'(x), longint'(y), ref_mul(4, 1'(m), longint'(x), longint'(y)),
                 -1, $sformatf("w4 m%0d %0d*%0d", m, x, y));
        end
      end
    end

    // WIDTH=16 random pairs, both modes, including the extreme corners.
    run_op(16, 1'b1, 64'h8000, 64'h8000, 64'h40000000, -1, "w16 min*min");
    run_op(16, 1'b0, 64'hFFFF, 64'hFFFF, 64'hFFFE0001, -1, "w16 max*max u");
    for (int i = 0; i < 2500; i++) begin
      a  = longint'($urandom);
      b  = longint'($urandom);
      sm = 1'(i % 2);
      run_op(16, sm, a, b, ref_mul(16, sm, a, b), -1, $sformatf("w16 rnd %0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
